// File: rtl/hc595_chain_driver.sv
`default_nettype none
// ============================================================================
// Module   : hc595_chain_driver
// Brief    : Serializes a parallel word MSB-first into a 74HC595 chain on a
//            divided shift clock, then pulses the storage latch.
// Revision : 1.0 - initial release
// ============================================================================
module hc595_chain_driver #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             frame_done,
    output logic             sr_ser,
    output logic             sr_clk,
    output logic             sr_latch,
    output logic             sr_oe_n
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_LATCH = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_DIV_W-1:0] r_div;
    logic [c_DIV_W-1:0] w_div_next;
    logic               r_phase;
    logic               w_phase_next;
    logic [c_BIT_W-1:0] r_bit;
    logic [c_BIT_W-1:0] w_bit_next;
    logic [c_BIT_W-1:0] w_bit_dec;
    logic [WIDTH-1:0]   r_shadow;
    logic [WIDTH-1:0]   w_shadow_next;
    logic               r_frame_done;
    logic               w_frame_done_next;
    logic               r_sr_ser;
    logic               w_sr_ser_next;
    logic               r_sr_clk;
    logic               w_sr_clk_next;
    logic               r_sr_latch;
    logic               w_sr_latch_next;
    logic               r_sr_oe_n;
    logic               w_sr_oe_n_next;

    logic w_div_end;
    logic w_last_bit;

    assign w_div_end  = (r_div == c_DIV_LAST);
    assign w_last_bit = (r_bit == '0);
    assign w_bit_dec  = r_bit - 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (load) w_state_next = c_SHIFT;
            c_SHIFT: if (w_div_end && r_phase && w_last_bit) w_state_next = c_LATCH;
            c_LATCH: if (w_div_end) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Data changes on the same edge that drops sr_clk, giving a full
    // low phase of setup before the next rising edge.
    always_comb begin
        w_div_next        = r_div;
        w_phase_next      = r_phase;
        w_bit_next        = r_bit;
        w_shadow_next     = r_shadow;
        w_frame_done_next = 1'b0;
        w_sr_ser_next     = r_sr_ser;
        w_sr_clk_next     = r_sr_clk;
        w_sr_latch_next   = r_sr_latch;
        w_sr_oe_n_next    = r_sr_oe_n;
        case (r_state)
            c_IDLE: begin
                if (load) begin
                    w_shadow_next = data_in;
                    w_sr_ser_next = data_in[WIDTH-1];
                    w_sr_clk_next = 1'b0;
                    w_div_next    = '0;
                    w_phase_next  = 1'b0;
                    w_bit_next    = c_BIT_LAST;
                end
            end
            c_SHIFT: begin
                if (w_div_end) begin
                    w_div_next = '0;
                    if (!r_phase) begin
                        w_phase_next  = 1'b1;
                        w_sr_clk_next = 1'b1;
                    end else begin
                        w_phase_next  = 1'b0;
                        w_sr_clk_next = 1'b0;
                        if (w_last_bit) begin
                            w_sr_latch_next = 1'b1;
                        end else begin
                            w_bit_next    = w_bit_dec;
                            w_sr_ser_next = r_shadow[w_bit_dec];
                        end
                    end
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            c_LATCH: begin
                if (w_div_end) begin
                    w_div_next        = '0;
                    w_sr_latch_next   = 1'b0;
                    w_frame_done_next = 1'b1;
                    w_sr_oe_n_next    = 1'b0;
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            default: begin
                w_div_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div        <= '0;
            r_phase      <= 1'b0;
            r_bit        <= c_BIT_LAST;
            r_shadow     <= '0;
            r_frame_done <= 1'b0;
            r_sr_ser     <= 1'b0;
            r_sr_clk     <= 1'b0;
            r_sr_latch   <= 1'b0;
            r_sr_oe_n    <= 1'b1;
        end else begin
            r_div        <= w_div_next;
            r_phase      <= w_phase_next;
            r_bit        <= w_bit_next;
            r_shadow     <= w_shadow_next;
            r_frame_done <= w_frame_done_next;
            r_sr_ser     <= w_sr_ser_next;
            r_sr_clk     <= w_sr_clk_next;
            r_sr_latch   <= w_sr_latch_next;
            r_sr_oe_n    <= w_sr_oe_n_next;
        end
    end

    assign ready      = (r_state == c_IDLE);
    assign frame_done = r_frame_done;
    assign sr_ser     = r_sr_ser;
    assign sr_clk     = r_sr_clk;
    assign sr_latch   = r_sr_latch;
    assign sr_oe_n    = r_sr_oe_n;

endmodule
`default_nettype wire
